// File: rtl/vcxo_pwm_dac.sv
// PWM / first-order sigma-delta DAC driving a VCXO loop filter from a signed
// correction word, with a per-period slew limit on the active duty.
module vcxo_pwm_dac #(
    parameter int WIDTH      = 16,
    parameter int PERIOD_MAX = 65499,
    parameter int SLEW_STEP  = 64
) (
    input  logic             pwm_clk_in,
    input  logic             reset_n_in,
    input  logic             enable,
    input  logic [WIDTH-1:0] VCXO_correction,
    input  logic             correction_valid,
    input  logic             mode,
    output logic             pump,
    output logic             period_start,
    output logic [WIDTH:0]   active_duty,
    output logic             saturated
);

    localparam int P_INT      = PERIOD_MAX + 1;
    localparam int OFFSET_INT = P_INT / 2;

    localparam logic [WIDTH-1:0]        CNT_MAX  = WIDTH'(PERIOD_MAX);
    localparam logic [WIDTH:0]          P_U      = (WIDTH+1)'(P_INT);
    localparam logic [WIDTH:0]          OFFSET_U = (WIDTH+1)'(OFFSET_INT);
    localparam logic [WIDTH:0]          STEP_U   = (WIDTH+1)'(SLEW_STEP);
    localparam logic signed [WIDTH+1:0] P_S      = (WIDTH+2)'(P_INT);
    localparam logic signed [WIDTH+1:0] OFFSET_S = (WIDTH+2)'(OFFSET_INT);

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH+1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] pending_reg, pending_next;
    logic [WIDTH:0]   duty_reg, duty_next;
    logic             sat_reg, sat_next;
    logic             mode_reg, mode_next;
    logic             pump_reg, pump_next;

    logic                    wrap;
    logic [WIDTH-1:0]        pend_eff;
    logic signed [WIDTH+1:0] target_raw;
    logic [WIDTH:0]          target_u;
    logic                    clamp_hit;
    logic [WIDTH:0]          slewed;
    logic [WIDTH+1:0]        sd_sum;

    // A strobe coinciding with the target computation is used immediately.
    always_comb begin
        wrap       = (cnt_reg == CNT_MAX);
        pend_eff   = correction_valid ? VCXO_correction : pending_reg;
        target_raw = $signed({{2{pend_eff[WIDTH-1]}}, pend_eff}) + OFFSET_S;

        target_u  = target_raw[WIDTH:0];
        clamp_hit = 1'b0;
        if (target_raw[WIDTH+1]) begin
            target_u  = '0;
            clamp_hit = 1'b1;
        end else if (target_raw > P_S) begin
            target_u  = P_U;
            clamp_hit = 1'b1;
        end

        if (target_u > duty_reg)
            slewed = ((target_u - duty_reg) <= STEP_U) ? target_u : duty_reg + STEP_U;
        else
            slewed = ((duty_reg - target_u) <= STEP_U) ? target_u : duty_reg - STEP_U;

        sd_sum = acc_reg + {1'b0, duty_reg};
    end

    always_comb begin
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        duty_next    = duty_reg;
        sat_next     = sat_reg;
        mode_next    = mode_reg;
        pump_next    = 1'b0;
        pending_next = correction_valid ? VCXO_correction : pending_reg;

        if (enable) begin
            cnt_next = wrap ? '0 : cnt_reg + 1'b1;
            if (mode_reg) begin
                if (sd_sum >= {1'b0, P_U}) begin
                    acc_next  = sd_sum - {1'b0, P_U};
                    pump_next = 1'b1;
                end else begin
                    acc_next  = sd_sum;
                    pump_next = 1'b0;
                end
            end else begin
                // Accumulator parked at zero so sigma-delta starts clean.
                acc_next  = '0;
                pump_next = ({1'b0, cnt_reg} < duty_reg);
            end
            if (wrap) begin
                duty_next = slewed;
                sat_next  = clamp_hit;
                mode_next = mode;
            end
        end else begin
            cnt_next = '0;
            acc_next = '0;
        end
    end

    always_ff @(posedge pwm_clk_in) begin
        if (!reset_n_in) begin
            cnt_reg     <= '0;
            acc_reg     <= '0;
            pending_reg <= '0;
            duty_reg    <= OFFSET_U;
            sat_reg     <= 1'b0;
            mode_reg    <= 1'b0;
            pump_reg    <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            pending_reg <= pending_next;
            duty_reg    <= duty_next;
            sat_reg     <= sat_next;
            mode_reg    <= mode_next;
            pump_reg    <= pump_next;
        end
    end

    assign pump         = pump_reg;
    assign active_duty  = duty_reg;
    assign saturated    = sat_reg;
    assign period_start = enable && reset_n_in && (cnt_reg == '0);

endmodule

// File: tb/tb_vcxo_pwm_dac.sv
// Table-driven bench for vcxo_pwm_dac: one record per PWM period, plus
// hand-written disable / re-enable / mid-period reset sequences.
module tb_vcxo_pwm_dac;

    logic       clk = 1'b0;
    logic       reset_n_in;
    logic       enable;
    logic [7:0] VCXO_correction;
    logic       correction_valid;
    logic       mode;
    logic       pump;
    logic       period_start;
    logic [8:0] active_duty;
    logic       saturated;

    int tests = 0;
    int fails = 0;

    vcxo_pwm_dac #(.WIDTH(8), .PERIOD_MAX(99), .SLEW_STEP(10)) dut (
        .pwm_clk_in      (clk),
        .reset_n_in      (reset_n_in),
        .enable          (enable),
        .VCXO_correction (VCXO_correction),
        .correction_valid(correction_valid),
        .mode            (mode),
        .pump            (pump),
        .period_start    (period_start),
        .active_duty     (active_duty),
        .saturated       (saturated)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               strobe;
        int               strobe_at;
        logic signed [7:0] corr;
        bit               mode_val;
        int               exp_duty;
        bit               exp_sat;
        int               exp_highs;
        bit               exp_adj;
    } vec_t;

    vec_t tbl [21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observes the 100 cycles following a counter=0 observation point.
    task automatic run_period(input vec_t v, output int highs, output int starts, output bit adj);
        bit prev;
        prev   = 1'b0;
        highs  = 0;
        starts = 0;
        adj    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (v.strobe && i == v.strobe_at) begin
                correction_valid = 1'b1;
                VCXO_correction  = v.corr;
            end
            if (i == 40) mode = v.mode_val;
            tick();
            correction_valid = 1'b0;
            if (pump) begin
                highs++;
                if (prev) adj = 1'b1;
            end
            prev = pump;
            if (period_start) starts++;
        end
    endtask

    function automatic vec_t mk(bit s, int at, logic signed [7:0] c, bit m,
                                int d, bit sat, int h, bit adj);
        vec_t v;
        v.strobe = s; v.strobe_at = at; v.corr = c; v.mode_val = m;
        v.exp_duty = d; v.exp_sat = sat; v.exp_highs = h; v.exp_adj = adj;
        return v;
    endfunction

    initial begin
        int   highs, starts, n, cnt_bad;
        bit   adj;
        vec_t idle;

        // Duty sequence: midscale, +60 clamps at 100, -128 clamps at 0,
        // -20 strobed on the wrap cycle itself, then sigma-delta at 30.
        tbl[0]  = mk(1, 10,   8'sd60, 0,  50, 0,  50, 1);
        tbl[1]  = mk(0,  0,    8'sd0, 0,  60, 1,  60, 1);
        tbl[2]  = mk(0,  0,    8'sd0, 0,  70, 1,  70, 1);
        tbl[3]  = mk(0,  0,    8'sd0, 0,  80, 1,  80, 1);
        tbl[4]  = mk(0,  0,    8'sd0, 0,  90, 1,  90, 1);
        tbl[5]  = mk(1, 10, -8'sd128, 0, 100, 1, 100, 1);
        tbl[6]  = mk(0,  0,    8'sd0, 0,  90, 1,  90, 1);
        tbl[7]  = mk(0,  0,    8'sd0, 0,  80, 1,  80, 1);
        tbl[8]  = mk(0,  0,    8'sd0, 0,  70, 1,  70, 1);
        tbl[9]  = mk(0,  0,    8'sd0, 0,  60, 1,  60, 1);
        tbl[10] = mk(0,  0,    8'sd0, 0,  50, 1,  50, 1);
        tbl[11] = mk(0,  0,    8'sd0, 0,  40, 1,  40, 1);
        tbl[12] = mk(0,  0,    8'sd0, 0,  30, 1,  30, 1);
        tbl[13] = mk(0,  0,    8'sd0, 0,  20, 1,  20, 1);
        tbl[14] = mk(0,  0,    8'sd0, 0,  10, 1,  10, 1);
        tbl[15] = mk(1, 99,  -8'sd20, 0,   0, 1,   0, 0);
        tbl[16] = mk(0,  0,    8'sd0, 0,  10, 0,  10, 1);
        tbl[17] = mk(0,  0,    8'sd0, 0,  20, 0,  20, 1);
        tbl[18] = mk(0,  0,    8'sd0, 1,  30, 0,  30, 1);
        tbl[19] = mk(0,  0,    8'sd0, 1,  30, 0,  30, 0);
        tbl[20] = mk(0,  0,    8'sd0, 1,  30, 0,  30, 0);

        reset_n_in       = 1'b0;
        enable           = 1'b0;
        VCXO_correction  = '0;
        correction_valid = 1'b0;
        mode             = 1'b0;
        tick();
        tick();
        check("reset_pump", int'(pump), 0);
        check("reset_period_start", int'(period_start), 0);
        check("reset_duty", int'(active_duty), 50);
        check("reset_saturated", int'(saturated), 0);
        $display("[TB] reset: pump=%0d duty=%0d sat=%0d", pump, active_duty, saturated);

        reset_n_in = 1'b1;
        enable     = 1'b1;
        #1;
        for (int r = 0; r < 21; r++) begin
            check($sformatf("row%0d_duty", r), int'(active_duty), tbl[r].exp_duty);
            check($sformatf("row%0d_sat", r), int'(saturated), int'(tbl[r].exp_sat));
            check($sformatf("row%0d_period_start", r), int'(period_start), 1);
            run_period(tbl[r], highs, starts, adj);
            check($sformatf("row%0d_highs", r), highs, tbl[r].exp_highs);
            check($sformatf("row%0d_starts", r), starts, 1);
            check($sformatf("row%0d_adjacent", r), int'(adj), int'(tbl[r].exp_adj));
            $display("[TB] row %0d: duty=%0d sat=%0d highs=%0d starts=%0d adj=%0d",
                     r, tbl[r].exp_duty, tbl[r].exp_sat, highs, starts, adj);
        end

        // Disable at counter=40.
        for (int i = 0; i < 40; i++) tick();
        enable = 1'b0;
        tick();
        check("dis_pump", int'(pump), 0);
        check("dis_period_start", int'(period_start), 0);
        check("dis_duty_held", int'(active_duty), 30);
        check("dis_sat_held", int'(saturated), 0);
        cnt_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pump || period_start) cnt_bad++;
        end
        check("dis_quiet", cnt_bad, 0);
        $display("[TB] disable: pump=%0d period_start=%0d duty=%0d", pump, period_start, active_duty);

        enable = 1'b1;
        #1;
        check("reen_period_start", int'(period_start), 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 200);
        check("reen_period_len", n, 100);
        $display("[TB] re-enable: next period_start after %0d cycles", n);

        // Reset at counter=70.
        for (int i = 0; i < 70; i++) tick();
        reset_n_in = 1'b0;
        tick();
        check("rst_duty", int'(active_duty), 50);
        check("rst_pump", int'(pump), 0);
        check("rst_period_start", int'(period_start), 0);
        check("rst_sat", int'(saturated), 0);
        $display("[TB] mid-period reset: duty=%0d pump=%0d", active_duty, pump);

        mode       = 1'b0;
        reset_n_in = 1'b1;
        #1;
        check("rel_period_start", int'(period_start), 1);
        idle = mk(0, 0, 8'sd0, 0, 50, 0, 50, 1);
        run_period(idle, highs, starts, adj);
        check("rel_highs", highs, 50);
        check("rel_starts", starts, 1);
        check("rel_adjacent_pwm", int'(adj), 1);
        check("rel_duty_after_wrap", int'(active_duty), 50);
        $display("[TB] after release: highs=%0d starts=%0d duty=%0d", highs, starts, active_duty);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
